// File: rtl/usbf_ep_buf_wb_pkg.sv
// Shared field offsets, descriptor constants and FSM encoding for the endpoint
// buffer write-back engine.
package usbf_ep_buf_wb_pkg;

  localparam int UC_BSEL_LSB = 30;
  localparam int UC_DPD_LSB  = 28;
  localparam int MAX_PL_SZ_W = 11;
  localparam logic [31:0] BUF_UNUSED = 32'hffff_ffff;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_MATCH = 4'd1,
    ST_LATCH = 4'd2,
    ST_CALC  = 4'd3,
    ST_WRBUF = 4'd4,
    ST_DPD   = 4'd5,
    ST_FIN   = 4'd6,
    ST_BSEL  = 4'd7,
    ST_BSET  = 4'd8,
    ST_DONE  = 4'd9
  } state_t;

endpackage

// File: rtl/usbf_buf_calc.sv
// Combinational buffer descriptor update: advance address, shrink size, and
// flag buffer completion on a short packet or a nearly exhausted buffer.
module usbf_buf_calc #(
  parameter int ADR_W = 17,
  parameter int SZ_W  = 14
) (
  input  logic [ADR_W-1:0] adr,
  input  logic [SZ_W-1:0]  sz,
  input  logic [10:0]      xfer_sz,
  input  logic [10:0]      max_pl_sz,
  output logic [ADR_W-1:0] new_adr,
  output logic [SZ_W-1:0]  new_sz,
  output logic             fin
);

  logic [SZ_W-1:0]  xfer_sz_ext;
  logic [ADR_W-1:0] xfer_adr_ext;

  assign xfer_sz_ext  = SZ_W'(xfer_sz);
  assign xfer_adr_ext = ADR_W'(xfer_sz);

  // Address wraps naturally at the field width; size saturates at zero.
  assign new_adr = adr + xfer_adr_ext;
  assign new_sz  = (sz > xfer_sz_ext) ? (sz - xfer_sz_ext) : '0;

  // A zero-length packet always terminates the buffer, even with max_pl_sz of 0.
  assign fin = (new_sz < SZ_W'(max_pl_sz)) || (xfer_sz < max_pl_sz) || (xfer_sz == 11'd0);

endmodule

// File: rtl/usbf_ep_buf_wb.sv
// Endpoint buffer write-back engine: after a transaction it reads the selected
// endpoint's csr/buffers and writes back the updated descriptor, dpd and bsel.
module usbf_ep_buf_wb #(
  parameter int MATCH_TO = 2,
  parameter int ADR_W    = 17,
  parameter int SZ_W     = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  ep_no,
  input  logic [10:0] xfer_sz,
  input  logic        xfer_err,
  output logic        busy,
  output logic        done,
  output logic        no_ep,
  output logic [3:0]  ep_sel,
  input  logic        ep_match,
  input  logic [31:0] csr,
  input  logic [31:0] buf0,
  input  logic [31:0] buf1,
  output logic [31:0] idin,
  output logic        buf0_set,
  output logic        buf1_set,
  output logic        uc_bsel_set,
  output logic        uc_dpd_set,
  output logic        buf0_rl,
  output logic        int_buf0_set,
  output logic        int_buf1_set
);
  import usbf_ep_buf_wb_pkg::*;

  localparam int CNT_W = $clog2(MATCH_TO + 1);

  state_t                 state, nxt;
  logic [CNT_W-1:0]       cnt;
  logic [10:0]            xsz_q;
  logic                   xerr_q;
  logic                   no_ep_q;
  logic [1:0]             bsel_q;
  logic [1:0]             dpd_q;
  logic [MAX_PL_SZ_W-1:0] mps_q;
  logic [31:0]            buf0_q;
  logic [31:0]            buf1_q;

  logic                   use_b1;
  logic                   buf1_unused;
  logic [31:0]            b_act;
  logic [ADR_W-1:0]       new_adr;
  logic [SZ_W-1:0]        new_sz;
  logic                   fin;
  logic                   accept;
  logic                   match_to_hit;
  logic                   csr_unused;

  assign csr_unused = ^csr[27:11];

  // Any uc_bsel other than 01 falls back to buffer 0.
  assign use_b1      = (bsel_q == 2'b01);
  assign b_act       = use_b1 ? buf1_q : buf0_q;
  assign buf1_unused = (buf1_q == BUF_UNUSED);
  assign accept      = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign match_to_hit = (cnt == CNT_W'(MATCH_TO - 1));

  usbf_buf_calc #(.ADR_W(ADR_W), .SZ_W(SZ_W)) u_calc (
    .adr       (b_act[ADR_W-1:0]),
    .sz        (b_act[ADR_W +: SZ_W]),
    .xfer_sz   (xsz_q),
    .max_pl_sz (mps_q),
    .new_adr   (new_adr),
    .new_sz    (new_sz),
    .fin       (fin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ep_sel  <= 4'h0;
      xsz_q   <= '0;
      xerr_q  <= 1'b0;
      no_ep_q <= 1'b0;
      bsel_q  <= '0;
      dpd_q   <= '0;
      mps_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        ep_sel  <= ep_no;
        xsz_q   <= xfer_sz;
        xerr_q  <= xfer_err;
        no_ep_q <= 1'b0;
        cnt     <= '0;
      end
      if (state == ST_MATCH) begin
        cnt <= cnt + 1'b1;
        if (!ep_match && match_to_hit) no_ep_q <= 1'b1;
      end
      if (state == ST_LATCH) begin
        bsel_q <= csr[UC_BSEL_LSB +: 2];
        dpd_q  <= csr[UC_DPD_LSB +: 2];
        mps_q  <= csr[MAX_PL_SZ_W-1:0];
        buf0_q <= buf0;
        buf1_q <= buf1;
      end
    end
  end

  always_comb begin
    nxt          = state;
    busy         = (state != ST_IDLE) && (state != ST_DONE);
    done         = 1'b0;
    no_ep        = 1'b0;
    idin         = '0;
    buf0_set     = 1'b0;
    buf1_set     = 1'b0;
    uc_bsel_set  = 1'b0;
    uc_dpd_set   = 1'b0;
    buf0_rl      = 1'b0;
    int_buf0_set = 1'b0;
    int_buf1_set = 1'b0;
    case (state)
      ST_IDLE:  if (start) nxt = ST_MATCH;
      ST_MATCH: begin
        if (ep_match)          nxt = ST_LATCH;
        else if (match_to_hit) nxt = ST_DONE;
      end
      ST_LATCH: nxt = xerr_q ? ST_DONE : ST_CALC;
      ST_CALC:  nxt = (b_act == BUF_UNUSED) ? ST_DONE : ST_WRBUF;
      ST_WRBUF: begin
        idin     = 32'({1'b0, new_sz, new_adr});
        buf0_set = !use_b1;
        buf1_set = use_b1;
        nxt      = ST_DPD;
      end
      ST_DPD: begin
        idin[UC_DPD_LSB +: 2] = dpd_q ^ 2'b01;
        uc_dpd_set = 1'b1;
        nxt        = fin ? ST_FIN : ST_DONE;
      end
      ST_FIN: begin
        int_buf0_set = !use_b1;
        int_buf1_set = use_b1;
        nxt          = ST_BSEL;
      end
      ST_BSEL: begin
        // Buffer 0 finished with no alternate: reload it before re-selecting it.
        if (!use_b1 && buf1_unused) begin
          buf0_rl = 1'b1;
          nxt     = ST_BSET;
        end else begin
          uc_bsel_set = 1'b1;
          idin[UC_BSEL_LSB +: 2] = use_b1 ? 2'b00 : 2'b01;
          nxt = ST_DONE;
        end
      end
      ST_BSET: begin
        uc_bsel_set = 1'b1;
        nxt         = ST_DONE;
      end
      ST_DONE: begin
        done  = 1'b1;
        no_ep = no_ep_q;
        nxt   = start ? ST_MATCH : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usbf_ep_buf_wb.sv
// Self-checking bench: an endpoint register-file model feeds the engine and a
// reference model predicts the strobe sequence of every write-back.
module tb_usbf_ep_buf_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ep_no = '0;
  logic [10:0] xfer_sz = '0;
  logic        xfer_err = 1'b0;
  logic        busy, done, no_ep, ep_match;
  logic [3:0]  ep_sel;
  logic [31:0] csr, buf0, buf1, idin;
  logic        buf0_set, buf1_set, uc_bsel_set, uc_dpd_set, buf0_rl, int_buf0_set, int_buf1_set;

  logic [31:0] csr_m  [16];
  logic [31:0] buf0_m [16];
  logic [31:0] buf1_m [16];
  logic        pres_m [16];

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;
  int ev_k[$];
  logic [31:0] ev_d[$];
  int exp_k[$];
  logic [31:0] exp_d[$];
  logic exp_no_ep;

  localparam int K_B0 = 0, K_B1 = 1, K_DPD = 2, K_I0 = 3, K_I1 = 4, K_RL = 5, K_BSEL = 6;
  localparam int MATCH_TO = 2;

  always #5 clk = ~clk;

  assign csr      = csr_m[ep_sel];
  assign buf0     = buf0_m[ep_sel];
  assign buf1     = buf1_m[ep_sel];
  assign ep_match = pres_m[ep_sel];

  usbf_ep_buf_wb #(.MATCH_TO(MATCH_TO), .ADR_W(17), .SZ_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .ep_no(ep_no), .xfer_sz(xfer_sz), .xfer_err(xfer_err),
    .busy(busy), .done(done), .no_ep(no_ep), .ep_sel(ep_sel), .ep_match(ep_match),
    .csr(csr), .buf0(buf0), .buf1(buf1), .idin(idin),
    .buf0_set(buf0_set), .buf1_set(buf1_set), .uc_bsel_set(uc_bsel_set), .uc_dpd_set(uc_dpd_set),
    .buf0_rl(buf0_rl), .int_buf0_set(int_buf0_set), .int_buf1_set(int_buf1_set)
  );

  // Strobe monitor: records every strobe and counts protocol violations.
  always @(negedge clk) begin
    int n;
    n = int'(buf0_set) + int'(buf1_set) + int'(uc_bsel_set) + int'(uc_dpd_set)
      + int'(buf0_rl) + int'(int_buf0_set) + int'(int_buf1_set);
    if (n > 1) viol++;
    if (n == 0 && idin !== 32'h0) viol++;
    if (n == 1) begin
      if (buf0_set)     ev_k.push_back(K_B0);
      if (buf1_set)     ev_k.push_back(K_B1);
      if (uc_dpd_set)   ev_k.push_back(K_DPD);
      if (int_buf0_set) ev_k.push_back(K_I0);
      if (int_buf1_set) ev_k.push_back(K_I1);
      if (buf0_rl)      ev_k.push_back(K_RL);
      if (uc_bsel_set)  ev_k.push_back(K_BSEL);
      ev_d.push_back(idin);
    end
  end

  function automatic logic [31:0] mk_buf(input int sz, input int adr);
    logic [31:0] b;
    b = (32'(sz & 32'h3fff) << 17) | 32'(adr & 32'h1ffff);
    return b;
  endfunction

  // Reference: what the register file should see for one transaction.
  task automatic ref_model(input int ep, input int xsz, input bit xerr);
    logic [31:0] c, b, b1v;
    int adr, sz, nadr, nsz, mps, bsel, dpd;
    bit use1, fin;
    exp_k.delete();
    exp_d.delete();
    exp_no_ep = 1'b0;
    if (!pres_m[ep]) begin
      exp_no_ep = 1'b1;
      return;
    end
    if (xerr) return;
    c = csr_m[ep];
    b1v = buf1_m[ep];
    bsel = int'(c >> 30);
    dpd = int'((c >> 28) & 32'h3);
    mps = int'(c & 32'h7ff);
    use1 = (bsel == 1);
    b = use1 ? b1v : buf0_m[ep];
    if (b == 32'hffff_ffff) return;
    adr = int'(b & 32'h1ffff);
    sz = int'((b >> 17) & 32'h3fff);
    nadr = (adr + xsz) % 131072;
    nsz = (sz > xsz) ? sz - xsz : 0;
    fin = (nsz < mps) || (xsz < mps) || (xsz == 0);
    exp_k.push_back(use1 ? K_B1 : K_B0);
    exp_d.push_back(mk_buf(nsz, nadr));
    exp_k.push_back(K_DPD);
    exp_d.push_back(32'(dpd ^ 1) << 28);
    if (fin) begin
      exp_k.push_back(use1 ? K_I1 : K_I0);
      exp_d.push_back(32'h0);
      if (!use1 && b1v == 32'hffff_ffff) begin
        exp_k.push_back(K_RL);
        exp_d.push_back(32'h0);
        exp_k.push_back(K_BSEL);
        exp_d.push_back(32'h0);
      end else begin
        exp_k.push_back(K_BSEL);
        exp_d.push_back(use1 ? 32'h0 : 32'h4000_0000);
      end
    end
  endtask

  task automatic run_txn(input string name, input int ep, input int xsz, input bit xerr, input int max_cyc);
    int base, v0, cyc;
    bit got;
    logic got_no_ep, got_busy;
    ref_model(ep, xsz, xerr);
    @(negedge clk);
    base = ev_k.size();
    v0 = viol;
    ep_no = 4'(ep);
    xfer_sz = 11'(xsz);
    xfer_err = xerr;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 1'b0;
    got_no_ep = 1'b0;
    got_busy = 1'b0;
    while (!got && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        n_cmp++;
        if (busy !== 1'b1 || ep_sel !== 4'(ep)) begin
          n_err++;
          $display("FAIL %s/select: busy=%b ep_sel=%0d, want busy=1 ep_sel=%0d", name, busy, ep_sel, ep);
        end
      end
      if (done === 1'b1) begin
        got = 1'b1;
        got_no_ep = no_ep;
        got_busy = busy;
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s/done: no done within %0d cycles", name, max_cyc);
      return;
    end
    @(negedge clk);
    n_cmp++;
    if (got_no_ep !== exp_no_ep || got_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s/status: no_ep=%b busy=%b, want no_ep=%b busy=0", name, got_no_ep, got_busy, exp_no_ep);
    end
    n_cmp++;
    if (viol != v0) begin
      n_err++;
      $display("FAIL %s/protocol: %0d strobe violations, want 0", name, viol - v0);
    end
    n_cmp++;
    if (ev_k.size() - base != exp_k.size()) begin
      n_err++;
      $display("FAIL %s/count: %0d strobes, want %0d", name, ev_k.size() - base, exp_k.size());
    end else begin
      foreach (exp_k[i]) begin
        n_cmp++;
        if (ev_k[base+i] != exp_k[i] || (exp_k[i] != K_RL && ev_d[base+i] !== exp_d[i])) begin
          n_err++;
          $display("FAIL %s/strobe%0d: kind=%0d idin=%h, want kind=%0d idin=%h",
                   name, i, ev_k[base+i], ev_d[base+i], exp_k[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic setup_ep(input int ep, input bit pres, input logic [31:0] c, input logic [31:0] b0, input logic [31:0] b1);
    pres_m[ep] = pres;
    csr_m[ep]  = c;
    buf0_m[ep] = b0;
    buf1_m[ep] = b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, no_ep, buf0_set, buf1_set, uc_bsel_set, uc_dpd_set, buf0_rl, int_buf0_set, int_buf1_set} !== 10'h0
        || ep_sel !== 4'h0 || idin !== 32'h0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b ep_sel=%h idin=%h, want all zero", busy, done, ep_sel, idin);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dummy_ep();
    setup_ep(3, 1'b0, 32'h0, 32'h0, 32'h0);
    run_txn("dummy_ep", 3, 64, 1'b0, MATCH_TO + 2);
  endtask

  task automatic test_normal();
    setup_ep(1, 1'b1, 32'd64, mk_buf(1024, 32'h100), 32'hffff_ffff);
    run_txn("normal", 1, 64, 1'b0, 20);
  endtask

  task automatic test_fin_bsel();
    setup_ep(2, 1'b1, 32'd64, mk_buf(64, 32'h0), mk_buf(256, 32'h800));
    run_txn("fin_bsel", 2, 64, 1'b0, 20);
  endtask

  task automatic test_short_pkt();
    setup_ep(4, 1'b1, 32'h4000_0040 | 32'h1000_0000, mk_buf(100, 32'h0), mk_buf(500, 32'h2000));
    run_txn("short_pkt", 4, 10, 1'b0, 20);
  endtask

  task automatic test_wrap_sat_rl();
    setup_ep(5, 1'b1, 32'h3000_0040, mk_buf(16, 32'h1fff0), 32'hffff_ffff);
    run_txn("wrap_sat_rl", 5, 32, 1'b0, 20);
  endtask

  task automatic test_edge_cases();
    setup_ep(6, 1'b1, 32'd64, mk_buf(300, 32'h40), mk_buf(300, 32'h80));
    run_txn("xfer_err", 6, 20, 1'b1, 20);
    setup_ep(7, 1'b1, 32'h4000_0040, mk_buf(300, 32'h40), 32'hffff_ffff);
    run_txn("unused_buf", 7, 20, 1'b0, 20);
    setup_ep(8, 1'b1, 32'd64, mk_buf(300, 32'h40), mk_buf(10, 32'h0));
    run_txn("zlp", 8, 0, 1'b0, 20);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit hit;
    setup_ep(9, 1'b1, 32'd64, mk_buf(1000, 32'h10), mk_buf(1000, 32'h20));
    @(negedge clk);
    ep_no = 4'd9;
    xfer_sz = 11'd64;
    xfer_err = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (buf0_set || buf1_set) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL reset_mid/reach: buffer write not seen within 20 cycles");
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, buf0_set, buf1_set, uc_bsel_set, uc_dpd_set, buf0_rl, int_buf0_set, int_buf1_set} !== 8'h0) begin
      n_err++;
      $display("FAIL reset_mid/abort: busy=%b b0=%b b1=%b dpd=%b, want all 0", busy, buf0_set, buf1_set, uc_dpd_set);
    end
    @(negedge clk);
    rst = 1'b0;
    run_txn("after_reset", 9, 64, 1'b0, 20);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int ep, mps, xsz;
      logic [31:0] c, b0, b1;
      ep = int'($urandom_range(0, 15));
      mps = int'($urandom_range(0, 600));
      c = (32'($urandom_range(0, 3)) << 30) | (32'($urandom_range(0, 3)) << 28) | 32'(mps);
      b0 = ($urandom_range(0, 5) == 0) ? 32'hffff_ffff : mk_buf(int'($urandom_range(0, 16383)), int'($urandom));
      b1 = ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : mk_buf(int'($urandom_range(0, 2000)), int'($urandom));
      setup_ep(ep, ($urandom_range(0, 7) != 0), c, b0, b1);
      xsz = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2047)) : mps;
      run_txn($sformatf("random%0d", it), ep, xsz & 32'h7ff, ($urandom_range(0, 7) == 0), 20);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) setup_ep(i, 1'b0, 32'h0, 32'hffff_ffff, 32'hffff_ffff);
    test_reset();
    test_dummy_ep();
    test_normal();
    test_fin_bsel();
    test_short_pkt();
    test_wrap_sat_rl();
    test_edge_cases();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
